// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared opcode encoding for the sequential arithmetic unit.
//            OP_W is the opcode width; OP_* are the operation codes.
// Revision : 1.0  initial release
// ============================================================================
package arith_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_ADC   = 3'b010;
  localparam logic [OP_W-1:0] OP_SBC   = 3'b011;
  localparam logic [OP_W-1:0] OP_NEG   = 3'b100;
  localparam logic [OP_W-1:0] OP_CMP   = 3'b101;
  localparam logic [OP_W-1:0] OP_ACC   = 3'b110;
  localparam logic [OP_W-1:0] OP_LDACC = 3'b111;

endpackage
`default_nettype wire

// File: rtl/arith_adder_core.sv
`default_nettype none
// ============================================================================
// Module   : arith_adder_core
// Purpose  : N-bit adder computing x + y + cin with carry out.
// Ports    : x, y   (in,  N) addends
//            cin    (in,  1) carry in
//            sum    (out, N) sum modulo 2^N
//            cout   (out, 1) carry out of bit N-1
// Revision : 1.0  initial release
// ============================================================================
module arith_adder_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full_sum;

  always_comb begin
    full_sum = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
  end

  assign sum  = full_sum[N-1:0];
  assign cout = full_sum[N];

endmodule
`default_nettype wire

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : arith_unit_seq
// Purpose  : Registered N-bit signed add/sub/negate unit with a one-deep
//            valid/ready result register, carry chaining, accumulator and
//            sticky overflow.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, op, A, B       operand side
//            clr_sticky                         clears sticky_ovf
//            out_valid/out_ready, RA            result side
//            carryOut, Overflow, Zero, L, G, E  flags of the held result
//            sticky_ovf, acc                    persistent state
// Revision : 1.0  initial release
// ============================================================================
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic            clr_sticky,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    RA,
  output logic            carryOut,
  output logic            Overflow,
  output logic            Zero,
  output logic            L,
  output logic            G,
  output logic            E,
  output logic            sticky_ovf,
  output logic [N-1:0]    acc
);

  logic            accept;
  logic [N-1:0]    add_x, add_y, add_sum;
  logic            add_cin, add_cout, add_ovf;
  logic [N-1:0]    cmp_lhs;

  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    ra_q, ra_d;
  logic            carry_q, carry_d;   // also serves as the ADC/SBC carry-in C
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            l_q, l_d, g_q, g_d, e_q, e_d;
  logic            sticky_q, sticky_d;
  logic [N-1:0]    acc_q, acc_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand selection: every op is funnelled through the one adder.
  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (op)
      OP_ADD:   begin add_x = A;         add_y = B;  add_cin = 1'b0;    end
      OP_SUB,
      OP_CMP:   begin add_x = A;         add_y = ~B; add_cin = 1'b1;    end
      OP_ADC:   begin add_x = A;         add_y = B;  add_cin = carry_q; end
      OP_SBC:   begin add_x = A;         add_y = ~B; add_cin = carry_q; end
      OP_NEG:   begin add_x = '0;        add_y = ~B; add_cin = 1'b1;    end
      OP_ACC:   begin add_x = acc_q;     add_y = B;  add_cin = 1'b0;    end
      default:  begin add_x = A;         add_y = B;  add_cin = 1'b0;    end
    endcase
  end

  arith_adder_core #(.N(N)) u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (add_x[N-1] == add_y[N-1]) && (add_sum[N-1] != add_x[N-1]);

  // ACC compares the accumulator against B; every other op compares A with B.
  assign cmp_lhs = (op == OP_ACC) ? acc_q : A;

  always_comb begin
    out_valid_d = out_valid_q;
    ra_d        = ra_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    l_d         = l_q;
    g_d         = g_q;
    e_d         = e_q;
    acc_d       = acc_q;

    if (accept) begin
      out_valid_d = 1'b1;
      ra_d        = add_sum;
      carry_d     = add_cout;
      ovf_d       = add_ovf;
      case (op)
        OP_CMP:   ra_d = A;
        OP_ACC:   acc_d = add_sum;
        OP_LDACC: begin
          ra_d    = B;
          acc_d   = B;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        default:  ;
      endcase
      zero_d = (ra_d == '0);
      l_d    = $signed(cmp_lhs) <  $signed(B);
      g_d    = $signed(cmp_lhs) >  $signed(B);
      e_d    = cmp_lhs == B;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // An overflowing accept in the same cycle as a clear leaves sticky set.
    sticky_d = (sticky_q && !clr_sticky) || (accept && ovf_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ra_q        <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      l_q         <= 1'b0;
      g_q         <= 1'b0;
      e_q         <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ra_q        <= ra_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      l_q         <= l_d;
      g_q         <= g_d;
      e_q         <= e_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign RA         = ra_q;
  assign carryOut   = carry_q;
  assign Overflow   = ovf_q;
  assign Zero       = zero_q;
  assign L          = l_q;
  assign G          = g_q;
  assign E          = e_q;
  assign sticky_ovf = sticky_q;
  assign acc        = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_unit_seq
// Purpose  : Directed self-checking bench for arith_unit_seq (N=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_arith_unit_seq;
  import arith_pkg::*;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] op = '0;
  logic [N-1:0]    A = '0;
  logic [N-1:0]    B = '0;
  logic            clr_sticky = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    RA;
  logic            carryOut, Overflow, Zero, L, G, E;
  logic            sticky_ovf;
  logic [N-1:0]    acc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arith_unit_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .A          (A),
    .B          (B),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .RA         (RA),
    .carryOut   (carryOut),
    .Overflow   (Overflow),
    .Zero       (Zero),
    .L          (L),
    .G          (G),
    .E          (E),
    .sticky_ovf (sticky_ovf),
    .acc        (acc)
  );

  // flags packed as {carryOut, Overflow, Zero, L, G, E}
  function automatic logic [5:0] flags();
    return {carryOut, Overflow, Zero, L, G, E};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One accepted op with out_ready high; returns #1 after the accepting edge.
  task automatic do_op(input logic [OP_W-1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    A  = a;
    B  = b;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ra",        32'(RA),        32'd0);
    check("rst_flags",     32'(flags()),   32'd0);
    check("rst_acc",       32'(acc),       32'd0);
    check("rst_sticky",    32'(sticky_ovf), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // ADD 100+50 overflows into -106
    do_op(OP_ADD, 8'd100, 8'd50);
    check("add_valid",  32'(out_valid),  32'd1);
    check("add_ra",     32'(RA),         32'h96);
    check("add_flags",  32'(flags()),    32'b010010);
    check("add_sticky", 32'(sticky_ovf), 32'd1);

    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    check("clr_sticky",     32'(sticky_ovf), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // SUB with borrow, CMP equal
    do_op(OP_SUB, 8'd5, 8'd7);
    check("sub_ra",    32'(RA),      32'hFE);
    check("sub_flags", 32'(flags()), 32'b000100);
    do_op(OP_CMP, 8'd7, 8'd7);
    check("cmp_ra",    32'(RA),      32'h07);
    check("cmp_flags", 32'(flags()), 32'b100001);

    // Multi-word chain: carry of ADD feeds the following ADC
    do_op(OP_ADD, 8'hFF, 8'h01);
    check("chain_add_ra",    32'(RA),      32'h00);
    check("chain_add_flags", 32'(flags()), 32'b101100);
    do_op(OP_ADC, 8'h00, 8'h00);
    check("chain_adc_ra",    32'(RA),      32'h01);
    check("chain_adc_flags", 32'(flags()), 32'b000001);

    // NEG boundaries
    do_op(OP_NEG, 8'h33, 8'h80);
    check("neg80_ra",    32'(RA),      32'h80);
    check("neg80_flags", 32'(flags()), 32'b010010);
    do_op(OP_NEG, 8'h00, 8'h01);
    check("neg01_ra",    32'(RA),      32'hFF);
    check("neg01_flags", 32'(flags()), 32'b000100);

    // Clear coinciding with an overflowing accept keeps sticky set
    @(negedge clk);
    clr_sticky = 1'b1;
    do_op(OP_ADD, 8'd100, 8'd50);
    check("clr_vs_ovf_sticky", 32'(sticky_ovf), 32'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    do_op(OP_SUB, 8'd9, 8'd4);
    check("clr_with_clean_op", 32'(sticky_ovf), 32'd0);

    // Accumulator
    do_op(OP_LDACC, 8'h10, 8'h7F);
    check("ldacc_ra",    32'(RA),      32'h7F);
    check("ldacc_acc",   32'(acc),     32'h7F);
    check("ldacc_flags", 32'(flags()), 32'b000100);
    do_op(OP_ACC, 8'h00, 8'h01);
    check("acc_ra",     32'(RA),         32'h80);
    check("acc_acc",    32'(acc),        32'h80);
    check("acc_flags",  32'(flags()),    32'b010010);
    check("acc_sticky", 32'(sticky_ovf), 32'd1);
    do_op(OP_SUB, 8'd3, 8'd1);
    check("sub_keep_ra",  32'(RA),  32'h02);
    check("sub_keep_acc", 32'(acc), 32'h80);

    // Back-pressure: held result, no accept while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = OP_ADD;
    A  = 8'd1;
    B  = 8'd2;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_ra",    32'(RA),        32'h02);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accept_ra", 32'(RA), 32'h03);
    idle_cycle();
    check("bp_one_result_valid", 32'(out_valid), 32'd0);
    check("bp_one_result_ra",    32'(RA),        32'h03);

    // Asynchronous reset while a result is held
    do_op(OP_ADD, 8'd100, 8'd50);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid",  32'(out_valid),  32'd0);
    check("midrst_ra",     32'(RA),         32'd0);
    check("midrst_flags",  32'(flags()),    32'd0);
    check("midrst_acc",    32'(acc),        32'd0);
    check("midrst_sticky", 32'(sticky_ovf), 32'd0);
    check("midrst_ready",  32'(in_ready),   32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Carry register cleared by reset: ADC 0+0 must give 0
    do_op(OP_ADC, 8'h00, 8'h00);
    check("post_rst_adc_ra",    32'(RA),      32'h00);
    check("post_rst_adc_flags", 32'(flags()), 32'b001001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
